intc: RTL and testbench

INTC -- requirements
Module: intc

---
 rtl/intc.sv | 171 +++++++++++++++++
 tb/tb_intc.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intc.sv
// rtl/intc.sv - eight-source prioritised interrupt controller with bus registers
//
// Ports:
//   clk      single clock, all state updates on its rising edge
//   rst_n    asynchronous active-low reset
//   din      bus write data (DW bits)
//   addr     bus register word address (AW bits)
//   we       1 = write din to addr, 0 = read addr into dout next cycle
//   dout     registered read data, holds while we=1
//   irq_src  interrupt sources, rising-edge detected ([0]=T0, [1]=T1, [7:2] spare)
//   irq_req  registered interrupt request to the CPU
//   irq_vec  registered index of the source requested or in service
//   irq_ack  CPU acknowledge pulse, honoured only while requesting
//
// Register map (word addresses):
//   0x00 ICTR  [0] global enable
//   0x01 IEN   [7:0] per-source enable
//   0x02 IPND  [7:0] pending, write-1-to-clear
//   0x03 IVEC  read {in_service, 0..., vec[2:0]}
//   0x04 EOI   any write ends service
module intc #(
    parameter int DW = 16,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] addr,
    input  logic          we,
    output logic [DW-1:0] dout,
    input  logic [7:0]    irq_src,
    output logic          irq_req,
    output logic [2:0]    irq_vec,
    input  logic          irq_ack
);

    localparam logic [AW-1:0] A_ICTR = AW'(0);
    localparam logic [AW-1:0] A_IEN  = AW'(1);
    localparam logic [AW-1:0] A_IPND = AW'(2);
    localparam logic [AW-1:0] A_IVEC = AW'(3);
    localparam logic [AW-1:0] A_EOI  = AW'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    state_t     state, state_n;
    logic       ictr, ictr_n;
    logic [7:0] ien, ien_n;
    logic [7:0] ipnd, ipnd_n;
    logic [7:0] src_q;
    logic       armed;
    logic [2:0] vec, vec_n;
    logic       req_q;

    logic [7:0]    edges;
    logic [7:0]    active;
    logic [2:0]    winner;
    logic [7:0]    w1c_mask;
    logic [7:0]    ack_mask;
    logic [DW-1:0] rd_data;
    logic          wr_ictr, wr_ien, wr_ipnd, wr_eoi;

    // Only the low byte of write data is architecturally used.
    logic unused_din;
    assign unused_din = ^din[DW-1:8];

    assign wr_ictr = we && (addr == A_ICTR);
    assign wr_ien  = we && (addr == A_IEN);
    assign wr_ipnd = we && (addr == A_IPND);
    assign wr_eoi  = we && (addr == A_EOI);

    // The first edge after reset release only samples the sources, so a
    // line already high when reset lifts is not mistaken for a new edge.
    assign edges  = armed ? (irq_src & ~src_q) : 8'h00;
    assign active = ipnd & ien;

    // Lowest index wins: scan from the top so lower bits overwrite.
    always_comb begin
        winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                winner = 3'(i);
            end
        end
    end

    assign ictr_n   = wr_ictr ? din[0] : ictr;
    assign ien_n    = wr_ien ? din[7:0] : ien;
    assign w1c_mask = wr_ipnd ? din[7:0] : 8'h00;
    assign ack_mask = ((state == S_REQ) && irq_ack) ? (8'h01 << vec) : 8'h00;

    // New edges are OR-ed in last so a same-cycle set beats any clear.
    assign ipnd_n = (ipnd & ~w1c_mask & ~ack_mask) | edges;

    always_comb begin
        state_n = state;
        vec_n   = vec;
        case (state)
            S_IDLE: begin
                if (ictr && (active != 8'h00)) begin
                    state_n = S_REQ;
                    vec_n   = winner;
                end
            end
            S_REQ: begin
                // Withdrawal is judged on the post-write values so that a
                // software clear drops irq_req on the very next cycle.
                if (irq_ack) begin
                    state_n = S_SERVICE;
                end else if (!ipnd_n[vec] || !ien_n[vec] || !ictr_n) begin
                    state_n = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (wr_eoi) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            A_ICTR: rd_data[0]   = ictr;
            A_IEN:  rd_data[7:0] = ien;
            A_IPND: rd_data[7:0] = ipnd;
            A_IVEC: begin
                rd_data[DW-1] = (state == S_SERVICE);
                rd_data[2:0]  = vec;
            end
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ictr  <= 1'b0;
            ien   <= 8'h00;
            ipnd  <= 8'h00;
            src_q <= 8'h00;
            armed <= 1'b0;
            vec   <= 3'd0;
            req_q <= 1'b0;
            dout  <= '0;
        end else begin
            state <= state_n;
            ictr  <= ictr_n;
            ien   <= ien_n;
            ipnd  <= ipnd_n;
            src_q <= irq_src;
            armed <= 1'b1;
            vec   <= vec_n;
            req_q <= (state_n == S_REQ);
            if (!we) begin
                dout <= rd_data;
            end
        end
    end

    assign irq_req = req_q;
    assign irq_vec = vec;

endmodule

// File: tb/tb_intc.sv
// tb/tb_intc.sv - self-checking bench for intc with directed and random stimulus
module tb_intc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din = 16'h0;
    logic [11:0] addr = 12'h0;
    logic        we = 1'b0;
    logic [7:0]  irq_src = 8'h0;
    logic        irq_ack = 1'b0;
    logic [15:0] dout;
    logic        irq_req;
    logic [2:0]  irq_vec;

    int checks = 0;
    int failures = 0;

    intc #(.DW(16), .AW(12)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .addr    (addr),
        .we      (we),
        .dout    (dout),
        .irq_src (irq_src),
        .irq_req (irq_req),
        .irq_vec (irq_vec),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    // Reference model: controller modes as two flags, pending/enables as bytes.
    bit          m_ictr;
    bit [7:0]    m_ien;
    bit [7:0]    m_ipnd;
    bit [7:0]    m_prev_src;
    bit          m_seen_clock;
    bit          m_waiting;
    bit          m_serving;
    int          m_vec;
    logic [15:0] m_dout;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ictr = 0;
        m_ien = 0;
        m_ipnd = 0;
        m_prev_src = 0;
        m_seen_clock = 0;
        m_waiting = 0;
        m_serving = 0;
        m_vec = 0;
        m_dout = 0;
    endtask

    // Predict one clock from the current inputs, clock the DUT, then compare.
    task automatic step();
        bit [7:0]    rise;
        bit [7:0]    enabled_pending;
        bit [7:0]    clear_bits;
        bit [7:0]    next_ipnd;
        bit [7:0]    next_ien;
        bit          next_ictr;
        int          first;
        int          a;
        logic [15:0] rd;

        a = int'(addr);
        rise = m_seen_clock ? (irq_src & ~m_prev_src) : 8'h00;
        enabled_pending = m_ipnd & m_ien;
        first = -1;
        for (int i = 0; i < 8; i++) begin
            if (enabled_pending[i] && first < 0) first = i;
        end

        if (a == 0)      rd = {15'h0, m_ictr};
        else if (a == 1) rd = {8'h0, m_ien};
        else if (a == 2) rd = {8'h0, m_ipnd};
        else if (a == 3) rd = {m_serving, 12'h0, 3'(m_vec)};
        else             rd = 16'h0;

        next_ictr = (we && a == 0) ? din[0] : m_ictr;
        next_ien  = (we && a == 1) ? din[7:0] : m_ien;
        clear_bits = (we && a == 2) ? din[7:0] : 8'h00;
        if (m_waiting && irq_ack) clear_bits[m_vec] = 1'b1;
        next_ipnd = (m_ipnd & ~clear_bits) | rise;

        if (m_waiting) begin
            if (irq_ack) begin
                m_waiting = 0;
                m_serving = 1;
            end else if (!next_ipnd[m_vec] || !next_ien[m_vec] || !next_ictr) begin
                m_waiting = 0;
            end
        end else if (m_serving) begin
            if (we && a == 4) m_serving = 0;
        end else if (m_ictr && first >= 0) begin
            m_waiting = 1;
            m_vec = first;
        end

        if (!we) m_dout = rd;
        m_ictr = next_ictr;
        m_ien = next_ien;
        m_ipnd = next_ipnd;
        m_prev_src = irq_src;
        m_seen_clock = 1;

        @(posedge clk);
        #1;
        chk("model_irq_req", 16'(irq_req), 16'(m_waiting));
        chk("model_irq_vec", 16'(irq_vec), 16'(m_vec));
        chk("model_dout", dout, m_dout);
    endtask

    task automatic wr(input logic [11:0] a, input logic [15:0] d);
        we = 1'b1;
        addr = a;
        din = d;
        step();
        we = 1'b0;
        din = 16'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [15:0] exp);
        we = 1'b0;
        addr = a;
        step();
        chk(tag, dout, exp);
    endtask

    task automatic pulse(input logic [7:0] mask);
        irq_src = mask;
        step();
        irq_src = 8'h00;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    initial begin
        model_reset();
        // Source already high while reset lifts must not register as an edge.
        irq_src = 8'h01;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_irq_req", 16'(irq_req), 16'h0);
        chk("reset_irq_vec", 16'(irq_vec), 16'h0);
        chk("reset_dout", dout, 16'h0);
        rst_n = 1'b1;
        repeat (3) step();
        irq_src = 8'h00;
        rd_chk("release_high_src_ipnd", 12'h002, 16'h0000);
        rd_chk("reset_ictr", 12'h000, 16'h0000);
        rd_chk("reset_ien", 12'h001, 16'h0000);

        // Single source, full request / ack / EOI round trip.
        wr(12'h000, 16'h0001);
        wr(12'h001, 16'h0003);
        pulse(8'h02);
        chk("lat_n1_req", 16'(irq_req), 16'h0);
        step();
        chk("lat_n2_req", 16'(irq_req), 16'h1);
        chk("lat_n2_vec", 16'(irq_vec), 16'h1);
        ack();
        chk("ack_drops_req", 16'(irq_req), 16'h0);
        rd_chk("ack_clears_ipnd", 12'h002, 16'h0000);
        rd_chk("ivec_in_service", 12'h003, 16'h8001);
        wr(12'h004, 16'h0000);
        rd_chk("ivec_after_eoi", 12'h003, 16'h0001);
        chk("eoi_req_low", 16'(irq_req), 16'h0);

        // Two simultaneous sources: lower index first, then the other.
        wr(12'h001, 16'h00FF);
        pulse(8'h21);
        step();
        chk("prio_first_req", 16'(irq_req), 16'h1);
        chk("prio_first_vec", 16'(irq_vec), 16'h0);
        ack();
        rd_chk("prio_ipnd_left", 12'h002, 16'h0020);
        wr(12'h004, 16'h0000);
        step();
        chk("prio_second_req", 16'(irq_req), 16'h1);
        chk("prio_second_vec", 16'(irq_vec), 16'h5);
        ack();
        wr(12'h004, 16'h0000);

        // Pending while disabled, then enabling raises the request.
        wr(12'h001, 16'h0000);
        pulse(8'h08);
        step();
        rd_chk("masked_ipnd", 12'h002, 16'h0008);
        chk("masked_no_req", 16'(irq_req), 16'h0);
        wr(12'h001, 16'h0008);
        step();
        chk("unmask_req", 16'(irq_req), 16'h1);
        chk("unmask_vec", 16'(irq_vec), 16'h3);
        ack();
        wr(12'h004, 16'h0000);

        // Software clear of the requested bit withdraws the request.
        wr(12'h001, 16'h0004);
        pulse(8'h04);
        step();
        chk("w1c_pre_req", 16'(irq_req), 16'h1);
        wr(12'h002, 16'h0004);
        chk("w1c_withdraw_req", 16'(irq_req), 16'h0);
        rd_chk("w1c_ivec_idle", 12'h003, 16'h0002);
        rd_chk("w1c_ipnd", 12'h002, 16'h0000);

        // Global disable before ack withdraws; pending survives.
        wr(12'h001, 16'h0001);
        pulse(8'h01);
        step();
        chk("ictr_pre_req", 16'(irq_req), 16'h1);
        wr(12'h000, 16'h0000);
        chk("ictr_withdraw_req", 16'(irq_req), 16'h0);
        rd_chk("ictr_ipnd_kept", 12'h002, 16'h0001);
        wr(12'h002, 16'h00FF);

        // Ack outside a request and EOI outside service do nothing.
        ack();
        wr(12'h004, 16'h0000);
        chk("stray_ack_req", 16'(irq_req), 16'h0);

        // Edge and write-1-to-clear of the same bit in one cycle: set wins.
        wr(12'h001, 16'h0000);
        pulse(8'h10);
        step();
        irq_src = 8'h10;
        wr(12'h002, 16'h0010);
        irq_src = 8'h00;
        rd_chk("set_beats_clear", 12'h002, 16'h0010);
        wr(12'h002, 16'h0010);
        rd_chk("plain_clear", 12'h002, 16'h0000);

        // A held-high source sets pending once only.
        irq_src = 8'h40;
        repeat (3) step();
        wr(12'h002, 16'h0040);
        repeat (2) step();
        rd_chk("held_high_once", 12'h002, 16'h0000);
        irq_src = 8'h00;

        // Randomised traffic against the model.
        wr(12'h000, 16'h0001);
        wr(12'h001, 16'h00FF);
        for (int n = 0; n < 600; n++) begin
            irq_src = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            we = ($urandom_range(0, 3) == 0);
            addr = 12'($urandom_range(0, 6));
            din = 16'($urandom);
            if (addr == 12'h000 && $urandom_range(0, 3) != 0) din[0] = 1'b1;
            irq_ack = ($urandom_range(0, 2) == 0);
            step();
        end
        irq_src = 8'h00;
        we = 1'b0;
        irq_ack = 1'b0;
        wr(12'h004, 16'h0000);

        // Asynchronous reset in the middle of service.
        wr(12'h000, 16'h0001);
        wr(12'h001, 16'h00FF);
        wr(12'h002, 16'h00FF);
        step();
        pulse(8'h04);
        step();
        ack();
        rd_chk("pre_reset_service", 12'h003, 16'h8002);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_req", 16'(irq_req), 16'h0);
        chk("async_rst_vec", 16'(irq_vec), 16'h0);
        chk("async_rst_dout", dout, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        rd_chk("post_rst_ictr", 12'h000, 16'h0000);
        rd_chk("post_rst_ien", 12'h001, 16'h0000);
        rd_chk("post_rst_ipnd", 12'h002, 16'h0000);
        rd_chk("post_rst_ivec", 12'h003, 16'h0000);
        rd_chk("post_rst_other", 12'h004, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
